// File: rtl/reg_dump_reader_if.sv
// Bus bundle between reg_dump_reader and its surroundings: dump request,
// register-file read ports, the valid/ready word stream and status.
// The master modport is the reader; the slave modport is the environment
// (requester, register file and debug consumer).
interface reg_dump_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] first_idx;
    logic [ADDR_W-1:0] last_idx;
    logic              reg_ena;
    logic [ADDR_W-1:0] RsC;
    logic [ADDR_W-1:0] RtC;
    logic [DATA_W-1:0] Rs_data_in;
    logic [DATA_W-1:0] Rt_data_in;
    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout_data;
    logic [ADDR_W-1:0] dout_idx;
    logic              dout_last;
    logic              busy;
    logic              done;

    modport master (
        input  start, first_idx, last_idx, Rs_data_in, Rt_data_in, dout_ready,
        output reg_ena, RsC, RtC, dout_valid, dout_data, dout_idx, dout_last,
               busy, done
    );

    modport slave (
        output start, first_idx, last_idx, Rs_data_in, Rt_data_in, dout_ready,
        input  reg_ena, RsC, RtC, dout_valid, dout_data, dout_idx, dout_last,
               busy, done
    );
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register-file index range two registers at a time
// through the RsC/RtC read ports and streams each value, tagged with its index,
// over a valid/ready output. All outputs come straight from flops.
// Optional feature macro: REG_DUMP_SKIP_ZERO_EN (suppress index 0 in the dump).
module reg_dump_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 reg_clk,
    input  logic                 rst_n,
    reg_dump_reader_if.master    bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    // Pointer is one bit wider than an index so that stepping past the top
    // register compares as "beyond hi" instead of wrapping to 0.
    localparam int PTR_W = ADDR_W + 1;

    logic [1:0]        state_q,      state_d;
    logic [PTR_W-1:0]  ptr_q,        ptr_d;
    logic [ADDR_W-1:0] hi_q,         hi_d;
    logic [DATA_W-1:0] slot1_data_q, slot1_data_d;
    logic              slot1_full_q, slot1_full_d;
    logic              reg_ena_q,    reg_ena_d;
    logic [ADDR_W-1:0] rsc_q,        rsc_d;
    logic [ADDR_W-1:0] rtc_q,        rtc_d;
    logic              valid_q,      valid_d;
    logic [DATA_W-1:0] data_q,       data_d;
    logic [ADDR_W-1:0] idx_q,        idx_d;
    logic              last_q,       last_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;

    logic [PTR_W-1:0]  hi_ext_s;
    logic [PTR_W-1:0]  ptr_p1_s;
    logic [PTR_W-1:0]  ptr_p2_s;
    logic              slot0_full_s;
    logic              slot1_ok_s;
    logic              empty_req_s;

    // Derived pointer arithmetic and slot occupancy for the current pair.
    always_comb begin
        hi_ext_s     = {1'b0, hi_q};
        ptr_p1_s     = ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        ptr_p2_s     = ptr_q + {{(PTR_W-2){1'b0}}, 2'b10};
        slot0_full_s = !(SKIP_ZERO && (ptr_q == {PTR_W{1'b0}}));
        slot1_ok_s   = (ptr_p1_s <= hi_ext_s);
        empty_req_s  = (bus.last_idx < bus.first_idx) ||
                       (SKIP_ZERO && (bus.last_idx == {ADDR_W{1'b0}}));
    end

    // Next-state logic for the dump sequencer and all registered outputs.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hi_d         = hi_q;
        slot1_data_d = slot1_data_q;
        slot1_full_d = slot1_full_q;
        valid_d      = valid_q;
        data_d       = data_q;
        idx_d        = idx_q;
        last_d       = last_q;
        reg_ena_d    = 1'b0;
        rsc_d        = {ADDR_W{1'b0}};
        rtc_d        = {ADDR_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    hi_d  = bus.last_idx;
                    ptr_d = {1'b0, bus.first_idx};
                    if (empty_req_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_FETCH;
                        reg_ena_d = 1'b1;
                        rsc_d     = bus.first_idx;
                        rtc_d     = bus.first_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // Words go out in index order, so slot0 is presented first
                // unless it was suppressed, in which case slot1 goes alone.
                state_d = ST_DRAIN;
                valid_d = 1'b1;
                if (slot0_full_s) begin
                    data_d       = bus.Rs_data_in;
                    idx_d        = ptr_q[ADDR_W-1:0];
                    last_d       = (ptr_q == hi_ext_s);
                    slot1_data_d = bus.Rt_data_in;
                    slot1_full_d = slot1_ok_s;
                end else begin
                    data_d       = bus.Rt_data_in;
                    idx_d        = ptr_p1_s[ADDR_W-1:0];
                    last_d       = (ptr_p1_s == hi_ext_s);
                    slot1_full_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (valid_q && bus.dout_ready) begin
                    if (slot1_full_q) begin
                        data_d       = slot1_data_q;
                        idx_d        = ptr_p1_s[ADDR_W-1:0];
                        last_d       = (ptr_p1_s == hi_ext_s);
                        slot1_full_d = 1'b0;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        ptr_d   = ptr_p2_s;
                        if (ptr_p2_s > hi_ext_s) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d   = ST_FETCH;
                            reg_ena_d = 1'b1;
                            rsc_d     = ptr_p2_s[ADDR_W-1:0];
                            rtc_d     = ptr_p2_s[ADDR_W-1:0] + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                valid_d      = 1'b0;
                slot1_full_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset abandons any dump in progress.
    always_ff @(posedge reg_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= {PTR_W{1'b0}};
            hi_q         <= {ADDR_W{1'b0}};
            slot1_data_q <= {DATA_W{1'b0}};
            slot1_full_q <= 1'b0;
            reg_ena_q    <= 1'b0;
            rsc_q        <= {ADDR_W{1'b0}};
            rtc_q        <= {ADDR_W{1'b0}};
            valid_q      <= 1'b0;
            data_q       <= {DATA_W{1'b0}};
            idx_q        <= {ADDR_W{1'b0}};
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hi_q         <= hi_d;
            slot1_data_q <= slot1_data_d;
            slot1_full_q <= slot1_full_d;
            reg_ena_q    <= reg_ena_d;
            rsc_q        <= rsc_d;
            rtc_q        <= rtc_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.reg_ena    = reg_ena_q;
    assign bus.RsC        = rsc_q;
    assign bus.RtC        = rtc_q;
    assign bus.dout_valid = valid_q;
    assign bus.dout_data  = data_q;
    assign bus.dout_idx   = idx_q;
    assign bus.dout_last  = last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: a register-file model answers the
// read ports, a scoreboard queue holds the words each dump must produce, and
// a negedge monitor pops and compares on every handshake.
module tb_reg_dump_reader;

`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        int         exp_cyc;
        string      name;
    } vec_t;

    logic        reg_clk;
    logic        rst_n;
    logic [31:0] rf [32];
    exp_t        sb_q [$];
    exp_t        e;
    int          n_checks;
    int          n_fail;
    logic        stall_seen;
    logic [31:0] stall_data;
    logic [4:0]  stall_idx;
    logic        stall_last;

    reg_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
        .reg_clk (reg_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    assign bus.Rs_data_in = bus.reg_ena ? rf[bus.RsC] : 32'hBAD0_0000;
    assign bus.Rt_data_in = bus.reg_ena ? rf[bus.RtC] : 32'hBAD0_0001;

    initial reg_clk = 1'b0;
    always #5 reg_clk = ~reg_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_range(input int f, input int l);
        for (int i = f; i <= l; i++) begin
            if (!(SKIP && i == 0)) begin
                sb_q.push_back('{idx: i[4:0], data: rf[i], last: (i == l)});
            end
        end
    endtask

    // Scoreboard pop on handshake, hold-while-stalled and read-port checks.
    always @(negedge reg_clk) begin
        if (rst_n) begin
            if (stall_seen && bus.dout_valid) begin
                chk("stall_data", {32'd0, bus.dout_data}, {32'd0, stall_data});
                chk("stall_idx",  {59'd0, bus.dout_idx}, {59'd0, stall_idx});
                chk("stall_last", {63'd0, bus.dout_last}, {63'd0, stall_last});
            end
            if (bus.reg_ena) begin
                chk("ena_vs_valid", {63'd0, bus.dout_valid}, 64'd0);
            end else begin
                chk("idle_addr", {54'd0, bus.RsC, bus.RtC}, 64'd0);
            end
            if (bus.dout_valid && bus.dout_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", {59'd0, bus.dout_idx}, 64'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("word_idx",  {59'd0, bus.dout_idx}, {59'd0, e.idx});
                    chk("word_data", {32'd0, bus.dout_data}, {32'd0, e.data});
                    chk("word_last", {63'd0, bus.dout_last}, {63'd0, e.last});
                end
            end
            stall_seen = bus.dout_valid && !bus.dout_ready;
            stall_data = bus.dout_data;
            stall_idx  = bus.dout_idx;
            stall_last = bus.dout_last;
        end else begin
            stall_seen = 1'b0;
        end
    end

    // Start one dump with ready held high and check the done timing.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                            input int exp_cyc, input string nm);
        int  cyc;
        int  busy_cyc;
        bit  got;
        push_range(int'(f), int'(l));
        @(negedge reg_clk);
        bus.start     = 1'b1;
        bus.first_idx = f;
        bus.last_idx  = l;
        @(posedge reg_clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        busy_cyc = 0;
        got = 1'b0;
        while (!got && cyc < 300) begin
            @(negedge reg_clk);
            cyc++;
            if (bus.busy) busy_cyc++;
            if (bus.done) got = 1'b1;
        end
        chk({nm, "_done_seen"}, {63'd0, got}, 64'd1);
        chk({nm, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({nm, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_cyc));
        @(negedge reg_clk);
        chk({nm, "_busy_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
        chk({nm, "_words_left"}, 64'(sb_q.size()), 64'd0);
    endtask

    vec_t vecs [8];
    int   pat [4];

    initial begin
        int   cyc;
        int   ena_cyc;
        bit   got;

        n_checks = 0;
        n_fail = 0;
        stall_seen = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.first_idx  = 5'd0;
        bus.last_idx   = 5'd0;
        bus.dout_ready = 1'b1;

`ifdef REG_DUMP_SKIP_ZERO_EN
        vecs[0] = '{5'd0,  5'd31, 48, "full"};
        vecs[6] = '{5'd0,  5'd0,  1,  "zero_only"};
        vecs[7] = '{5'd0,  5'd2,  5,  "zero_to_two"};
`else
        vecs[0] = '{5'd0,  5'd31, 49, "full"};
        vecs[6] = '{5'd0,  5'd0,  3,  "zero_only"};
        vecs[7] = '{5'd0,  5'd2,  6,  "zero_to_two"};
`endif
        vecs[1] = '{5'd5,  5'd5,  3,  "single5"};
        vecs[2] = '{5'd9,  5'd3,  1,  "empty"};
        vecs[3] = '{5'd2,  5'd4,  6,  "two_to_four"};
        vecs[4] = '{5'd30, 5'd31, 4,  "top_pair"};
        vecs[5] = '{5'd31, 5'd31, 3,  "top_single"};
        pat = '{1, 0, 0, 1};

        #12;
        chk("reset_outputs", {bus.dout_valid, bus.dout_last, bus.busy, bus.done,
                              bus.reg_ena, bus.RsC, bus.RtC, bus.dout_idx}, 64'd0);
        chk("reset_data", {32'd0, bus.dout_data}, 64'd0);
        @(negedge reg_clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_dump(vecs[v].first, vecs[v].last, vecs[v].exp_cyc, vecs[v].name);
        end

        // Back-pressure: ready follows 1,0,0,1 repeating over range 0..3.
        push_range(0, 3);
        @(negedge reg_clk);
        bus.start     = 1'b1;
        bus.first_idx = 5'd0;
        bus.last_idx  = 5'd3;
        @(posedge reg_clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        ena_cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            bus.dout_ready = (pat[cyc % 4] != 0);
            if (bus.reg_ena) ena_cyc++;
            if (bus.done) got = 1'b1;
            @(posedge reg_clk);
            #1;
            cyc++;
        end
        bus.dout_ready = 1'b1;
        chk("stall_done_seen", {63'd0, got}, 64'd1);
        chk("stall_words_left", 64'(sb_q.size()), 64'd0);
        chk("stall_fetch_cycles", 64'(ena_cyc), 64'd2);

        // Reset in the middle of a full dump, while word 10 is on the bus.
        push_range(0, 31);
        @(negedge reg_clk);
        bus.start     = 1'b1;
        bus.first_idx = 5'd0;
        bus.last_idx  = 5'd31;
        @(posedge reg_clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge reg_clk);
            cyc++;
            if (bus.dout_valid && bus.dout_idx == 5'd10) got = 1'b1;
        end
        chk("mid_reset_reached_idx10", {63'd0, got}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {bus.dout_valid, bus.dout_last, bus.busy, bus.done,
                                  bus.reg_ena, bus.RsC, bus.RtC, bus.dout_idx}, 64'd0);
        chk("mid_reset_data", {32'd0, bus.dout_data}, 64'd0);
        sb_q.delete();
        repeat (2) @(posedge reg_clk);
        #1;
        chk("reset_held_idle", {62'd0, bus.busy, bus.dout_valid}, 64'd0);
        @(negedge reg_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge reg_clk);
        chk("no_resume", {62'd0, bus.busy, bus.dout_valid}, 64'd0);
        run_dump(5'd2, 5'd4, 6, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
